multi_level_sync: RTL

//   Multi-channel level synchroniser with glitch filter and edge detection.

---
 rtl/multi_level_sync.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/multi_level_sync.sv
// ---------------------------------------------------------------------------
// multi_level_sync
//   Multi-channel level synchroniser with glitch filter and edge detection.
//   Each asynchronous level input passes through a SYNC_STAGES flop chain.
//   A per-channel stability counter then accepts a new level only after it has
//   been seen for FILT_CYCLES consecutive cycles. The block drives the clean
//   level and single-cycle rise/fall pulses. Every output comes from a
//   register, so there is no combinational path from async_in to any output.
//
//   Optional feature macro: LEVEL_SYNC_STICKY_EN
//     When this macro is defined, the chg_clr/chg_flag ports and the sticky
//     per-channel change flags are present.
//
// Parameters
//   WIDTH        number of independent channels (>=1)
//   SYNC_STAGES  synchroniser flops per channel (>=2)
//   FILT_CYCLES  consecutive stable cycles needed to accept a level (>=1)
//   RST_LEVEL    reset value of the sync chain, level_out and filter state
//
// Ports
//   clk        in   1      destination clock
//   rst_n      in   1      synchronous reset, active low
//   async_in   in   WIDTH  asynchronous level inputs
//   level_out  out  WIDTH  filtered, synchronised levels
//   rise_o     out  WIDTH  one-cycle pulse: level_out went 0->1
//   fall_o     out  WIDTH  one-cycle pulse: level_out went 1->0
//   chg_clr    in   WIDTH  clear sticky change flags   (LEVEL_SYNC_STICKY_EN)
//   chg_flag   out  WIDTH  sticky level-changed flags  (LEVEL_SYNC_STICKY_EN)
// ---------------------------------------------------------------------------
module multi_level_sync #(
  parameter int unsigned       WIDTH       = 4,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       FILT_CYCLES = 4,
  parameter logic [WIDTH-1:0]  RST_LEVEL   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
`ifdef LEVEL_SYNC_STICKY_EN
  ,
  input  logic [WIDTH-1:0] chg_clr,
  output logic [WIDTH-1:0] chg_flag
`endif
);

  localparam int unsigned     CNT_W   = $clog2(FILT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_CYCLES - 1);

  // Synchroniser chain: index 0 captures async_in, last index feeds the filter.
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];

  // Per-channel stability counters.
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q,  rise_d;
  logic [WIDTH-1:0] fall_q,  fall_d;
  logic [WIDTH-1:0] sv;

  assign sv = sync_q[SYNC_STAGES-1];

  // Synchroniser next state: plain shift.
  always_comb begin
    sync_d[0] = async_in;
    for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Filter next state: a channel's count only advances while the synchronised
  // value disagrees with the accepted level; any agreement restarts it, which
  // is what rejects glitches shorter than FILT_CYCLES.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sv[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = sv[i];
          rise_d[i]  = sv[i];
          fall_d[i]  = ~sv[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // State registers; reset discards any partial qualification.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= RST_LEVEL;
      end
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      level_q <= RST_LEVEL;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_out = level_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;

`ifdef LEVEL_SYNC_STICKY_EN
  logic [WIDTH-1:0] chg_q, chg_d;

  // Sticky flags: a new edge wins over a simultaneous clear.
  always_comb begin
    chg_d = chg_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (rise_d[i] || fall_d[i]) begin
        chg_d[i] = 1'b1;
      end else if (chg_clr[i]) begin
        chg_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chg_q <= '0;
    end else begin
      chg_q <= chg_d;
    end
  end

  assign chg_flag = chg_q;
`endif

endmodule
